fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, IF/ID pipeline register, BOOT/RUN/HOLD control
// Optional FETCH_PERF_CNT_EN adds FETCH_COUNT and BUBBLE_COUNT event counters.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter logic [31:0] NOP_INSTR    = 32'h00006033
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] PC,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PC4,
  output logic [31:0] IFID_INSTRUCTION,
  output logic        IFID_VALID
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] BUBBLE_COUNT
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic        in_fetch;
  logic        fetch_evt;
  logic        bubble_evt;
  logic [31:0] pc_plus4;
  logic        unused_target_bits;

  // Redirect outranks stall, so a branch arriving while held is taken at once.
  assign in_fetch   = (state == RUN) || (state == HOLD);
  assign fetch_evt  = in_fetch && !BRANCH_TAKEN && !STALL;
  assign bubble_evt = (state == BOOT) || (in_fetch && BRANCH_TAKEN);
  assign pc_plus4   = PC + 32'd4;

  assign unused_target_bits = ^BRANCH_TARGET[1:0];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      PC               <= {RESET_VECTOR[31:2], 2'b00};
      IFID_PC          <= 32'd0;
      IFID_PC4         <= 32'd0;
      IFID_INSTRUCTION <= NOP_INSTR;
      IFID_VALID       <= 1'b0;
      state            <= BOOT;
    end else if (bubble_evt) begin
      if (state == BOOT) begin
        PC <= {RESET_VECTOR[31:2], 2'b00};
      end else begin
        PC <= {BRANCH_TARGET[31:2], 2'b00};
      end
      IFID_PC          <= 32'd0;
      IFID_PC4         <= 32'd0;
      IFID_INSTRUCTION <= NOP_INSTR;
      IFID_VALID       <= 1'b0;
      state            <= RUN;
    end else if (fetch_evt) begin
      PC               <= pc_plus4;
      IFID_PC          <= PC;
      IFID_PC4         <= pc_plus4;
      IFID_INSTRUCTION <= INSTRUCTION;
      IFID_VALID       <= 1'b1;
      state            <= RUN;
    end else if (in_fetch) begin
      state <= HOLD;
    end else begin
      // Unused encoding: restart cleanly through BOOT.
      state <= BOOT;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      FETCH_COUNT  <= 32'd0;
      BUBBLE_COUNT <= 32'd0;
    end else begin
      if (fetch_evt) begin
        FETCH_COUNT <= FETCH_COUNT + 32'd1;
      end
      if (bubble_evt) begin
        BUBBLE_COUNT <= BUBBLE_COUNT + 32'd1;
      end
    end
  end
`else
  logic unused_evts;
  assign unused_evts = fetch_evt ^ bubble_evt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a behavioural fetch model
module tb_fetch_unit;

  localparam logic [31:0] RV  = 32'h00000000;
  localparam logic [31:0] NOP = 32'h00006033;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTRUCTION;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'd0;
  logic [31:0] PC;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_PC4;
  logic [31:0] IFID_INSTRUCTION;
  logic        IFID_VALID;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FETCH_COUNT;
  logic [31:0] BUBBLE_COUNT;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_pc, m_ipc, m_ipc4, m_ins;
  logic        m_valid;
  bit          m_boot;
  logic [31:0] m_fetches, m_bubbles;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign INSTRUCTION = mem_word(PC);

  fetch_unit #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .INSTRUCTION(INSTRUCTION),
    .STALL(STALL),
    .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET),
    .PC(PC),
    .IFID_PC(IFID_PC),
    .IFID_PC4(IFID_PC4),
    .IFID_INSTRUCTION(IFID_INSTRUCTION),
    .IFID_VALID(IFID_VALID)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FETCH_COUNT(FETCH_COUNT),
    .BUBBLE_COUNT(BUBBLE_COUNT)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic load_bubble();
    m_ipc = 32'd0; m_ipc4 = 32'd0; m_ins = NOP; m_valid = 1'b0;
    m_bubbles = m_bubbles + 32'd1;
  endtask

  // Next IF/ID and PC as described by the fetch rules, one clock at a time.
  task automatic model_step(input bit rst, input bit stall, input bit br, input logic [31:0] tgt);
    if (!rst) begin
      m_pc = RV; m_ipc = 32'd0; m_ipc4 = 32'd0; m_ins = NOP; m_valid = 1'b0;
      m_boot = 1'b1; m_fetches = 32'd0; m_bubbles = 32'd0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      load_bubble();
    end else if (br) begin
      m_pc = tgt & 32'hFFFFFFFC;
      load_bubble();
    end else if (!stall) begin
      m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_ins = mem_word(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      m_fetches = m_fetches + 32'd1;
    end
  endtask

  task automatic compare_all();
    check("pc", PC, m_pc);
    check("ifid_pc", IFID_PC, m_ipc);
    check("ifid_pc4", IFID_PC4, m_ipc4);
    check("ifid_instr", IFID_INSTRUCTION, m_ins);
    check("ifid_valid", {31'd0, IFID_VALID}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", FETCH_COUNT, m_fetches);
    check("bubble_count", BUBBLE_COUNT, m_bubbles);
`endif
  endtask

  // Called just after a negedge: apply inputs, cross one posedge, compare at the next negedge.
  task automatic cycle(input bit rst, input bit stall, input bit br, input logic [31:0] tgt);
    RESET = rst; STALL = stall; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
    model_step(rst, stall, br, tgt);
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
  endtask

  initial begin
    logic [31:0] tgt;
    bit rst, stl, br;
    m_boot = 1'b1; m_fetches = 32'd0; m_bubbles = 32'd0;
    @(negedge CLK);
    cycle(1'b0, 1'b1, 1'b1, 32'h44);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("reset_valid", {31'd0, IFID_VALID}, 32'd0);
    check("reset_instr", IFID_INSTRUCTION, NOP);

    // Boot then two fetches
    cycle(1'b1, 1'b1, 1'b1, 32'h80);
    check("boot_pc", PC, 32'd0);
    check("boot_valid", {31'd0, IFID_VALID}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("first_ifid_pc", IFID_PC, 32'd0);
    check("first_valid", {31'd0, IFID_VALID}, 32'd1);
    check("first_pc", PC, 32'd4);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("second_ifid_pc", IFID_PC, 32'd4);
    check("second_pc", PC, 32'd8);

    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("stall_pc", PC, 32'd8);
      check("stall_ifid_pc", IFID_PC, 32'd4);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("unstall_ifid_pc", IFID_PC, 32'd8);
    check("unstall_pc", PC, 32'd12);

    cycle(1'b1, 1'b0, 1'b1, 32'h40);
    check("redir_pc", PC, 32'h40);
    check("redir_valid", {31'd0, IFID_VALID}, 32'd0);
    check("redir_instr", IFID_INSTRUCTION, NOP);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("redir_ifid_pc", IFID_PC, 32'h40);
    check("redir_next_valid", {31'd0, IFID_VALID}, 32'd1);

    cycle(1'b1, 1'b1, 1'b1, 32'h23);
    check("br_stall_pc", PC, 32'h20);
    check("br_stall_ifid_pc", IFID_PC, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("br_stall_then_run", IFID_PC, 32'h20);

    cycle(1'b1, 1'b0, 1'b1, 32'hFFFFFFFE);
    check("wrap_target_pc", PC, 32'hFFFFFFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("wrap_pc", PC, 32'd0);
    check("wrap_ifid_pc4", IFID_PC4, 32'd0);
    check("wrap_ifid_pc", IFID_PC, 32'hFFFFFFFC);

    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 32'h100);
    check("rst_in_stall_pc", PC, RV);
    check("rst_in_stall_valid", {31'd0, IFID_VALID}, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      stl = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0: tgt = $urandom;
        1: tgt = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        default: tgt = 32'($urandom_range(0, 255));
      endcase
      cycle(rst, stl, br, tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
